// File: rtl/mem_resp_pkg.sv
// Shared encodings for the memory responder: request sizes, FSM states
// and the wait-state counter width.
package mem_resp_pkg;

  // Wide enough for the full 0..15 wait-state range.
  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic for a big-endian 32-bit word window.
// Bit k of be / wr_word[8k+:8] / rd_word[8k+:8] is the byte at offset 3-k
// from the word base, so the byte at the lowest address sits in [31:24].
module mem_lane_align
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_word,
  output logic        err,
  output logic [3:0]  be,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data
);

  logic        misalign;
  logic        out_of_range;
  logic [31:0] byte_shift;

  // Error decision, byte enables, write steering and read extraction.
  always_comb begin
    misalign     = ((size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                   ((size == SZ_HALF) && addr[0]);
    out_of_range = ((addr >> ADDR_W) != 32'd0);
    err          = misalign || out_of_range || (size == SZ_RSVD);
    byte_shift   = rd_word >> {(2'd3 - addr[1:0]), 3'b000};
    be           = 4'b0000;
    wr_word      = 32'd0;
    rd_data      = 32'd0;
    case (size)
      SZ_WORD: begin
        be      = 4'b1111;
        wr_word = wdata;
        rd_data = rd_word;
      end
      SZ_HALF: begin
        be      = addr[1] ? 4'b0011 : 4'b1100;
        wr_word = {wdata[15:0], wdata[15:0]};
        rd_data = {16'd0, (addr[1] ? rd_word[15:0] : rd_word[31:16])};
      end
      SZ_BYTE: begin
        be      = 4'b1000 >> addr[1:0];
        wr_word = {4{wdata[7:0]}};
        rd_data = {24'd0, byte_shift[7:0]};
      end
      default: ;
    endcase
    // A rejected request must never touch the array.
    if (err) be = 4'b0000;
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: valid/ready request port, programmable wait
// states, big-endian byte array, response held until consumed.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int    ADDR_W      = 8,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wait_q;
  logic                we_q;
  logic [1:0]          size_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic                err_q;

  logic                accept;
  logic                commit;
  logic                idle;

  logic                cur_we;
  logic [1:0]          cur_size;
  logic [31:0]         cur_addr;
  logic [31:0]         cur_wdata;
  logic                cur_err;

  logic [7:0]          mem [0:(1<<ADDR_W)-1];
  logic [31:0]         rd_word;
  logic                a_err;
  logic [3:0]          a_be;
  logic [31:0]         a_wr_word;
  logic [31:0]         a_rd_data;

  assign idle      = (state_q == IDLE);
  // Gated by reset so nothing is accepted while reset is held low.
  assign req_ready = reset && idle;
  assign rsp_valid = (state_q == RESP);

  // With zero wait states the commit edge is the accept edge itself, so the
  // lane logic looks at the live request in IDLE and the latched one after.
  always_comb begin
    cur_we    = idle ? req_write : we_q;
    cur_size  = idle ? req_size  : size_q;
    cur_addr  = idle ? req_addr  : addr_q;
    cur_wdata = idle ? req_wdata : wdata_q;
    cur_err   = idle ? a_err     : err_q;
  end

  // Word window around the addressed byte, lowest address in the MSB.
  always_comb begin
    rd_word = {mem[{cur_addr[ADDR_W-1:2], 2'd0}],
               mem[{cur_addr[ADDR_W-1:2], 2'd1}],
               mem[{cur_addr[ADDR_W-1:2], 2'd2}],
               mem[{cur_addr[ADDR_W-1:2], 2'd3}]};
  end

  mem_lane_align #(.ADDR_W(ADDR_W)) u_align (
    .size    (cur_size),
    .addr    (cur_addr),
    .wdata   (cur_wdata),
    .rd_word (rd_word),
    .err     (a_err),
    .be      (a_be),
    .wr_word (a_wr_word),
    .rd_data (a_rd_data)
  );

  // Next-state logic; commit marks the edge that enters RESP.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_q == WCNT_W'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latches, wait counter and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      err_q     <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_write;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= a_err;
        wait_q  <= WCNT_W'(WAIT_CYCLES);
      end else if (state_q == WAIT) begin
        wait_q <= wait_q - WCNT_W'(1);
      end
      if (commit) begin
        rsp_err   <= cur_err;
        rsp_rdata <= (cur_we || cur_err) ? 32'd0 : a_rd_data;
      end
    end
  end

  // Array update on the commit edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && cur_we) begin
      for (int k = 0; k < 4; k++) begin
        if (a_be[k]) mem[{cur_addr[ADDR_W-1:2], 2'(3 - k)}] <= a_wr_word[8*k +: 8];
      end
    end
  end

endmodule
